// File: rtl/seg7_capture.sv
// seg7_capture: receives a 7-segment bus {g,f,e,d,c,b,a}, synchronises it to clk,
// filters transients and decodes committed patterns back to hex digits.
// Ports: clk/reset (sync, active-high); seg_in async segment bus;
//        digit/digit_valid hold the last commit; digit_stb, pattern_err, seq_err
//        are one-cycle pulses; accept_count counts accepted digits (wraps).
module seg7_capture #(
   parameter int STABLE_CYCLES = 16,
   parameter bit ACTIVE_LOW    = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] seg_in,
   output logic [3:0] digit,
   output logic       digit_valid,
   output logic       digit_stb,
   output logic       pattern_err,
   output logic       seq_err,
   output logic [7:0] accept_count
);

   localparam logic [15:0] CNT_MAX    = 16'(STABLE_CYCLES - 1);
   localparam logic [15:0] CNT_COMMIT = 16'(STABLE_CYCLES - 2);

   logic [6:0]  w_seg;
   logic [6:0]  r_sync1;
   logic [6:0]  r_sync2;
   logic [6:0]  r_cand;
   logic [15:0] r_cnt;
   logic [6:0]  r_last_pat;
   logic [3:0]  r_prev;
   logic        r_had_prev;

   logic        w_commit;
   logic        w_legal;
   logic        w_blank;
   logic [3:0]  w_dec;
   logic [3:0]  w_next;

   assign w_seg    = ACTIVE_LOW ? ~seg_in : seg_in;
   // Fires on exactly one edge per stable run: the counter saturates one
   // step past the commit value, so it cannot pass CNT_COMMIT again.
   assign w_commit = (r_sync2 == r_cand) && (r_cnt == CNT_COMMIT);
   assign w_blank  = (r_sync2 == 7'h00);
   assign w_next   = r_prev + 4'd1;

   always_comb begin
      w_legal = 1'b1;
      w_dec   = 4'h0;
      case (r_sync2)
         7'h3F: w_dec = 4'h0;
         7'h06: w_dec = 4'h1;
         7'h5B: w_dec = 4'h2;
         7'h4F: w_dec = 4'h3;
         7'h66: w_dec = 4'h4;
         7'h6D: w_dec = 4'h5;
         7'h7D: w_dec = 4'h6;
         7'h07: w_dec = 4'h7;
         7'h7F: w_dec = 4'h8;
         7'h6F: w_dec = 4'h9;
         7'h77: w_dec = 4'hA;
         7'h7C: w_dec = 4'hB;
         7'h39: w_dec = 4'hC;
         7'h5E: w_dec = 4'hD;
         7'h79: w_dec = 4'hE;
         7'h71: w_dec = 4'hF;
         default: w_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1      <= 7'h00;
         r_sync2      <= 7'h00;
         r_cand       <= 7'h00;
         r_cnt        <= 16'h0000;
         r_last_pat   <= 7'h00;
         r_prev       <= 4'h0;
         r_had_prev   <= 1'b0;
         digit        <= 4'h0;
         digit_valid  <= 1'b0;
         digit_stb    <= 1'b0;
         pattern_err  <= 1'b0;
         seq_err      <= 1'b0;
         accept_count <= 8'h00;
      end else begin
         r_sync1     <= w_seg;
         r_sync2     <= r_sync1;
         digit_stb   <= 1'b0;
         pattern_err <= 1'b0;
         seq_err     <= 1'b0;

         if (r_sync2 != r_cand) begin
            r_cand <= r_sync2;
            r_cnt  <= 16'h0000;
         end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 16'h0001;
         end

         // A run that settles back on the already-committed pattern is a
         // glitch that healed itself: nothing to report.
         if (w_commit && (r_sync2 != r_last_pat)) begin
            r_last_pat <= r_sync2;
            if (w_legal) begin
               digit        <= w_dec;
               digit_valid  <= 1'b1;
               digit_stb    <= 1'b1;
               accept_count <= accept_count + 8'h01;
               seq_err      <= r_had_prev && (w_dec != w_next);
               r_prev       <= w_dec;
               r_had_prev   <= 1'b1;
            end else begin
               digit_valid <= 1'b0;
               pattern_err <= !w_blank;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_capture.sv
module tb_seg7_capture;

   localparam int S = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] seg_in = 7'h00;
   logic [6:0] seg_in_n;

   logic [3:0] digit_a, digit_b;
   logic       valid_a, valid_b, stb_a, stb_b, perr_a, perr_b, serr_a, serr_b;
   logic [7:0] cnt_a, cnt_b;

   assign seg_in_n = ~seg_in;

   seg7_capture #(.STABLE_CYCLES(S), .ACTIVE_LOW(1'b0)) u_dut_hi (
      .clk(clk), .reset(reset), .seg_in(seg_in),
      .digit(digit_a), .digit_valid(valid_a), .digit_stb(stb_a),
      .pattern_err(perr_a), .seq_err(serr_a), .accept_count(cnt_a));

   seg7_capture #(.STABLE_CYCLES(S), .ACTIVE_LOW(1'b1)) u_dut_lo (
      .clk(clk), .reset(reset), .seg_in(seg_in_n),
      .digit(digit_b), .digit_valid(valid_b), .digit_stb(stb_b),
      .pattern_err(perr_b), .seq_err(serr_b), .accept_count(cnt_b));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [6:0] pats [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Returns digit 0..15, -1 for blank, -2 for illegal.
   function automatic int decode(input logic [6:0] p);
      if (p == 7'h00) return -1;
      for (int i = 0; i < 16; i++)
         if (pats[i] == p) return i;
      return -2;
   endfunction

   // Pipeline of conditioned samples, and the length of the current run of
   // identical synchronised values seen at successive edges.
   logic [6:0] m_s1, m_s2, m_runv, m_last;
   int         m_runlen, m_prev, m_had, m_digit, m_valid, m_stb, m_perr, m_serr, m_cnt;
   bit         chk_en = 0;

   initial begin
      m_s1 = 0; m_s2 = 0; m_runv = 0; m_last = 0; m_runlen = 1;
      m_prev = 0; m_had = 0; m_digit = 0; m_valid = 0;
      m_stb = 0; m_perr = 0; m_serr = 0; m_cnt = 0;
   end

   always @(posedge clk) begin
      logic [6:0] q;
      int d;
      if (reset) begin
         m_s1 = 0; m_s2 = 0; m_runv = 0; m_runlen = 1; m_last = 0;
         m_prev = 0; m_had = 0; m_digit = 0; m_valid = 0;
         m_stb = 0; m_perr = 0; m_serr = 0; m_cnt = 0;
      end else begin
         q = m_s2;
         if (q == m_runv) begin
            if (m_runlen <= S) m_runlen++;
         end else begin
            m_runv = q;
            m_runlen = 1;
         end
         m_stb = 0; m_perr = 0; m_serr = 0;
         if (m_runlen == S && q != m_last) begin
            m_last = q;
            d = decode(q);
            if (d >= 0) begin
               m_serr  = (m_had != 0 && d != (m_prev + 1) % 16) ? 1 : 0;
               m_digit = d; m_valid = 1; m_stb = 1;
               m_cnt   = (m_cnt + 1) % 256;
               m_prev  = d; m_had = 1;
            end else begin
               m_valid = 0;
               m_perr  = (d == -2) ? 1 : 0;
            end
         end
         m_s2 = m_s1;
         m_s1 = seg_in;
      end
   end

   // Per-cycle comparison against the model plus DUT pulse tallies.
   int n_stb = 0, n_perr = 0, n_serr = 0, n_serr_stb = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         check("digit",        32'(digit_a), 32'(m_digit));
         check("digit_valid",  32'(valid_a), 32'(m_valid));
         check("digit_stb",    32'(stb_a),   32'(m_stb));
         check("pattern_err",  32'(perr_a),  32'(m_perr));
         check("seq_err",      32'(serr_a),  32'(m_serr));
         check("accept_count", 32'(cnt_a),   32'(m_cnt));
         check("active_low_outputs",
               {13'd0, digit_b, valid_b, stb_b, perr_b, serr_b, cnt_b},
               {13'd0, 4'(m_digit), 1'(m_valid), 1'(m_stb), 1'(m_perr), 1'(m_serr), 8'(m_cnt)});
         n_stb  += int'(stb_a);
         n_perr += int'(perr_a);
         n_serr += int'(serr_a);
         if (stb_a && serr_a) n_serr_stb++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic hold(input logic [6:0] p, input int n);
      seg_in = p;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_tallies();
      n_stb = 0; n_perr = 0; n_serr = 0; n_serr_stb = 0;
   endtask

   // Edges from the sampling edge to the strobe edge.
   task automatic measure_latency(input string tag);
      int edges;
      edges = 0;
      while (edges < 100) begin
         step();
         edges++;
         if (stb_a) break;
      end
      check(tag, 32'(edges - 1), 32'(S + 1));
   endtask

   initial begin
      reset = 1;
      seg_in = 7'h00;
      step(); step();
      chk_en = 1;
      step();
      check("reset_count", 32'(cnt_a), 32'd0);
      check("reset_valid", 32'(valid_a), 32'd0);

      // First digit and its latency.
      reset = 0;
      seg_in = 7'h3F;
      measure_latency("first_latency");
      check("first_digit", 32'(digit_a), 32'd0);
      check("first_count", 32'(cnt_a), 32'd1);
      check("first_seq_err", 32'(serr_a), 32'd0);
      hold(7'h3F, 20);

      // Full count-up 1..F then wrap to 0.
      clear_tallies();
      for (int i = 1; i <= 16; i++) hold(pats[i % 16], 40);
      check("count_up_strobes", 32'(n_stb), 32'd16);
      check("count_up_seq_errs", 32'(n_serr), 32'd0);
      check("count_up_total", 32'(cnt_a), 32'd17);
      check("count_up_last", 32'(digit_a), 32'd0);

      // Skipped digit: 1 then 3.
      clear_tallies();
      hold(7'h06, 40);
      hold(7'h4F, 40);
      check("skip_seq_with_stb", 32'(n_serr_stb), 32'd1);
      check("skip_seq_total", 32'(n_serr), 32'd1);
      check("skip_digit", 32'(digit_a), 32'd3);

      // Illegal pattern between 1 and 4.
      hold(7'h06, 40);
      clear_tallies();
      hold(7'h55, 40);
      check("illegal_pulses", 32'(n_perr), 32'd1);
      check("illegal_valid", 32'(valid_a), 32'd0);
      check("illegal_digit_hold", 32'(digit_a), 32'd1);
      clear_tallies();
      hold(7'h66, 40);
      check("after_illegal_digit", 32'(digit_a), 32'd4);
      check("after_illegal_seq", 32'(n_serr), 32'd1);

      // Short glitches never commit.
      hold(7'h5B, 40);
      clear_tallies();
      for (int i = 0; i < 20; i++) begin
         hold(7'h5B, 9);
         hold(7'h7F, 1);
      end
      hold(7'h5B, 20);
      check("glitch_no_pulses", 32'(n_stb + n_perr + n_serr), 32'd0);
      check("glitch_digit", 32'(digit_a), 32'd2);
      check("glitch_digit_active_low", 32'(digit_b), 32'd2);

      // Digit, blank, same digit: re-accepted with a sequence error.
      clear_tallies();
      hold(7'h00, 40);
      check("blank_valid", 32'(valid_a), 32'd0);
      hold(7'h5B, 40);
      check("reblank_stb", 32'(n_stb), 32'd1);
      check("reblank_seq", 32'(n_serr), 32'd1);

      // Reset in the middle of a hold.
      hold(7'h07, 40);
      check("pre_reset_digit", 32'(digit_a), 32'd7);
      reset = 1;
      step();
      check("mid_reset_digit", 32'(digit_a), 32'd0);
      check("mid_reset_count", 32'(cnt_a), 32'd0);
      reset = 0;
      measure_latency("post_reset_latency");
      check("post_reset_digit", 32'(digit_a), 32'd7);
      check("post_reset_seq", 32'(serr_a), 32'd0);
      check("post_reset_count", 32'(cnt_a), 32'd1);

      // Random traffic against the model.
      for (int n = 0; n < 150; n++) begin
         int r;
         logic [6:0] p;
         r = $urandom_range(0, 99);
         if (r < 40)      p = pats[(m_prev + 1) % 16];
         else if (r < 60) p = pats[$urandom_range(0, 15)];
         else if (r < 75) p = 7'h00;
         else             p = 7'($urandom_range(0, 127));
         if ($urandom_range(0, 49) == 0) begin
            reset = 1;
            step();
            reset = 0;
         end
         hold(p, $urandom_range(1, 40));
      end
      hold(7'h3F, 40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
